// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
//   Shared constants for the machine-mode interrupt arbiter: word width,
//   mip/mie bit positions, mcause codes, the interrupt flag position, FSM
//   state encoding, and small helpers to build an mcause word and a
//   single-bit mask.
// ----------------------------------------------------------------------------
package irq_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] xlen_t;

    // Bit positions in mip/mie
    localparam int MSI_BIT = 3;
    localparam int MTI_BIT = 7;
    localparam int MEI_BIT = 11;

    // mcause exception codes for the interrupts above
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // mcause interrupt flag
    localparam int IRQ_FLAG_BIT = XLEN - 1;

    // Arbiter FSM encoding
    localparam logic [1:0] IRQ_IDLE = 2'd0;
    localparam logic [1:0] IRQ_REQ  = 2'd1;
    localparam logic [1:0] IRQ_COOL = 2'd2;

    // Build the mcause word for an interrupt code: flag bit set, code in [3:0]
    function automatic xlen_t make_cause(input logic [3:0] code);
        xlen_t cause;
        cause               = '0;
        cause[IRQ_FLAG_BIT] = 1'b1;
        cause[3:0]          = code;
        return cause;
    endfunction

    // One-hot word with only bit 'pos' set
    function automatic xlen_t bit_mask(input int pos);
        xlen_t mask;
        mask      = '0;
        mask[pos] = 1'b1;
        return mask;
    endfunction

endpackage : irq_pkg

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Single-bit two-flop synchroniser with synchronous reset to 0. Brings an
//   asynchronous level into the clk_i domain.
//
// Ports
//   clk_i  in   destination clock
//   rst_i  in   synchronous active-high reset
//   din    in   asynchronous input level
//   dout   out  synchronised level (two clk_i edges of latency)
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din,
    output logic dout
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    assign dout = sync_reg;

endmodule : sync_2ff

// File: rtl/irq_arbiter.sv
// ----------------------------------------------------------------------------
// irq_arbiter
//   Machine-mode interrupt arbiter. Registers the CLINT timer/software lines
//   and the (synchronised) external line into a live mip view, masks them
//   with mie / mstatus.MIE, picks one by fixed priority (MEI > MSI > MTI) and
//   presents it to the pipeline as a request with a frozen mcause under a
//   request/acknowledge handshake. Also drives a WFI wakeup indication.
//
// Ports
//   clk_i           in   core clock
//   rst_i           in   synchronous active-high reset
//   timer_irq_i     in   CLINT timer level (MTIP)
//   software_irq_i  in   CLINT software level (MSIP)
//   ext_irq_i       in   external interrupt level, asynchronous
//   mstatus_mie_i   in   global M-mode interrupt enable
//   mie_i           in   mie CSR (bits 3/7/11 used)
//   mip_o           out  pending view: bit3 MSIP, bit7 MTIP, bit11 MEIP
//   irq_req_o       out  interrupt request to the pipeline
//   irq_cause_o     out  mcause for the request, held until the next latch
//   irq_ack_i       in   single-cycle pulse: pipeline took the trap
//   wakeup_o        out  any pending & enabled, ignoring mstatus.MIE
// ----------------------------------------------------------------------------
module irq_arbiter
    import irq_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            timer_irq_i,
    input  logic            software_irq_i,
    input  logic            ext_irq_i,
    input  logic            mstatus_mie_i,
    input  logic [XLEN-1:0] mie_i,
    output logic [XLEN-1:0] mip_o,
    output logic            irq_req_o,
    output logic [XLEN-1:0] irq_cause_o,
    input  logic            irq_ack_i,
    output logic            wakeup_o
);

    // Only these mip/mie bits exist in this block
    localparam xlen_t IRQ_BITS = bit_mask(MSI_BIT) | bit_mask(MTI_BIT) | bit_mask(MEI_BIT);

    // ------------------------------------------------------------------------
    // Source capture
    // ------------------------------------------------------------------------
    logic  ext_sync;
    xlen_t mip_next;
    xlen_t mip_reg;

    sync_2ff u_ext_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din   (ext_irq_i),
        .dout  (ext_sync)
    );

    // Route each source to its mip bit; every other bit is hard zero.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_mip
            if (gi == MSI_BIT) begin : g_msi
                assign mip_next[gi] = software_irq_i;
            end else if (gi == MTI_BIT) begin : g_mti
                assign mip_next[gi] = timer_irq_i;
            end else if (gi == MEI_BIT) begin : g_mei
                assign mip_next[gi] = ext_sync;
            end else begin : g_zero
                assign mip_next[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mip_reg <= '0;
        end else begin
            mip_reg <= mip_next;
        end
    end

    assign mip_o = mip_reg;

    // ------------------------------------------------------------------------
    // Enable masking and priority selection
    // ------------------------------------------------------------------------
    xlen_t      en;
    logic       any_en;
    logic       take;
    logic [3:0] win_code;
    xlen_t      win_mask;

    assign en       = mip_reg & mie_i & IRQ_BITS;
    assign any_en   = |en;
    assign take     = any_en & mstatus_mie_i;
    assign wakeup_o = any_en;

    always_comb begin
        win_code = '0;
        win_mask = '0;
        if (en[MEI_BIT]) begin
            win_code = CAUSE_MEI;
            win_mask = bit_mask(MEI_BIT);
        end else if (en[MSI_BIT]) begin
            win_code = CAUSE_MSI;
            win_mask = bit_mask(MSI_BIT);
        end else if (en[MTI_BIT]) begin
            win_code = CAUSE_MTI;
            win_mask = bit_mask(MTI_BIT);
        end
    end

    // ------------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------------
    logic [1:0] state_reg;
    logic [1:0] state_next;
    xlen_t      cause_reg;
    xlen_t      cause_next;
    // One-hot mip bit of the latched cause, used to detect withdrawal
    xlen_t      sel_mask_reg;
    xlen_t      sel_mask_next;
    logic       sel_still_en;

    assign sel_still_en = |(en & sel_mask_reg);

    always_comb begin
        state_next    = state_reg;
        cause_next    = cause_reg;
        sel_mask_next = sel_mask_reg;
        case (state_reg)
            IRQ_IDLE: begin
                // The only place the cause is ever re-latched
                if (take) begin
                    state_next    = IRQ_REQ;
                    cause_next    = make_cause(win_code);
                    sel_mask_next = win_mask;
                end
            end
            IRQ_REQ: begin
                // Ack has priority over a simultaneous withdraw
                if (irq_ack_i) begin
                    state_next = IRQ_COOL;
                end else if (!mstatus_mie_i || !sel_still_en) begin
                    state_next = IRQ_IDLE;
                end
            end
            IRQ_COOL: begin
                // Gives the CSR file one cycle to make its MIE clear visible
                state_next = IRQ_IDLE;
            end
            default: begin
                state_next = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IRQ_IDLE;
            cause_reg    <= '0;
            sel_mask_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cause_reg    <= cause_next;
            sel_mask_reg <= sel_mask_next;
        end
    end

    assign irq_req_o   = (state_reg == IRQ_REQ);
    assign irq_cause_o = cause_reg;

endmodule : irq_arbiter

// File: tb/tb_irq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_irq_arbiter
//   Directed-vector bench for irq_arbiter. Inputs change on the falling edge
//   and outputs are sampled on the falling edge, so each step() is exactly
//   one rising edge of the DUT clock.
// ----------------------------------------------------------------------------
module tb_irq_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        timer_irq_i;
    logic        software_irq_i;
    logic        ext_irq_i;
    logic        mstatus_mie_i;
    logic [31:0] mie_i;
    logic [31:0] mip_o;
    logic        irq_req_o;
    logic [31:0] irq_cause_o;
    logic        irq_ack_i;
    logic        wakeup_o;

    int n_vec;
    int n_err;

    irq_arbiter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .timer_irq_i    (timer_irq_i),
        .software_irq_i (software_irq_i),
        .ext_irq_i      (ext_irq_i),
        .mstatus_mie_i  (mstatus_mie_i),
        .mie_i          (mie_i),
        .mip_o          (mip_o),
        .irq_req_o      (irq_req_o),
        .irq_cause_o    (irq_cause_o),
        .irq_ack_i      (irq_ack_i),
        .wakeup_o       (wakeup_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_i          = 1'b1;
        timer_irq_i    = 1'b0;
        software_irq_i = 1'b0;
        ext_irq_i      = 1'b0;
        mstatus_mie_i  = 1'b0;
        mie_i          = 32'h0;
        irq_ack_i      = 1'b0;
        step(2);

        // Reset state
        check_vec("rst_req",    {31'b0, irq_req_o}, 32'h0);
        check_vec("rst_cause",  irq_cause_o,        32'h0);
        check_vec("rst_mip",    mip_o,              32'h0);
        check_vec("rst_wakeup", {31'b0, wakeup_o},  32'h0);
        rst_i = 1'b0;
        step(1);

        // Timer only: cycle 0 raise, mip at 1, req at 2, ack at 4, req low at 5
        mie_i = 32'h80; mstatus_mie_i = 1'b1; timer_irq_i = 1'b1;
        step(1);
        check_vec("tmr_c1_mip", mip_o,              32'h80);
        check_vec("tmr_c1_req", {31'b0, irq_req_o}, 32'h0);
        step(1);
        check_vec("tmr_c2_req",   {31'b0, irq_req_o}, 32'h1);
        check_vec("tmr_c2_cause", irq_cause_o,        32'h80000007);
        step(2);
        check_vec("tmr_c4_req", {31'b0, irq_req_o}, 32'h1);
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        check_vec("tmr_c5_cool_req", {31'b0, irq_req_o}, 32'h0);
        step(1);
        check_vec("tmr_c6_idle_req", {31'b0, irq_req_o}, 32'h0);
        step(1);
        check_vec("tmr_c7_rereq", {31'b0, irq_req_o}, 32'h1);
        // Source falls: mip drops after one edge, request withdrawn one edge later
        timer_irq_i = 1'b0;
        step(1);
        check_vec("tmr_fall_mip", mip_o,              32'h0);
        check_vec("tmr_fall_req", {31'b0, irq_req_o}, 32'h1);
        step(1);
        check_vec("tmr_withdraw_req", {31'b0, irq_req_o}, 32'h0);
        check_vec("tmr_cause_hold",   irq_cause_o,        32'h80000007);

        // Priority: all three pending at once
        mie_i = 32'h888; mstatus_mie_i = 1'b0;
        timer_irq_i = 1'b1; software_irq_i = 1'b1; ext_irq_i = 1'b1;
        step(3);
        check_vec("all_mip",    mip_o,              32'h888);
        check_vec("all_wakeup", {31'b0, wakeup_o},  32'h1);
        check_vec("all_noreq",  {31'b0, irq_req_o}, 32'h0);
        mstatus_mie_i = 1'b1;
        step(1);
        check_vec("all_req",   {31'b0, irq_req_o}, 32'h1);
        check_vec("all_cause", irq_cause_o,        32'h8000000B);
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        ext_irq_i = 1'b0; mstatus_mie_i = 1'b0;
        step(3);
        check_vec("swtm_mip", mip_o, 32'h088);
        mstatus_mie_i = 1'b1;
        step(1);
        check_vec("swtm_cause", irq_cause_o, 32'h80000003);
        // Freeze: external arrives while in REQ
        ext_irq_i = 1'b1;
        step(4);
        check_vec("frz_mip",   mip_o,              32'h888);
        check_vec("frz_req",   {31'b0, irq_req_o}, 32'h1);
        check_vec("frz_cause", irq_cause_o,        32'h80000003);
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        step(2);
        check_vec("frz_rereq_cause", irq_cause_o, 32'h8000000B);
        timer_irq_i = 1'b0; software_irq_i = 1'b0; ext_irq_i = 1'b0;
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        step(3);
        check_vec("clr_mip", mip_o,              32'h0);
        check_vec("clr_req", {31'b0, irq_req_o}, 32'h0);

        // Masking
        timer_irq_i = 1'b1; mie_i = 32'h80; mstatus_mie_i = 1'b0;
        step(2);
        check_vec("msk_gl_req",    {31'b0, irq_req_o}, 32'h0);
        check_vec("msk_gl_wakeup", {31'b0, wakeup_o},  32'h1);
        mie_i = 32'h0;
        step(1);
        check_vec("msk_mie_wakeup", {31'b0, wakeup_o}, 32'h0);
        check_vec("msk_mie_mip",    mip_o,             32'h80);

        // Withdraw vs ack
        mie_i = 32'h80; mstatus_mie_i = 1'b1;
        step(1);
        check_vec("wd_req", {31'b0, irq_req_o}, 32'h1);
        mstatus_mie_i = 1'b0;
        step(1);
        check_vec("wd_drop", {31'b0, irq_req_o}, 32'h0);
        mstatus_mie_i = 1'b1;
        step(1);
        check_vec("wd_req2", {31'b0, irq_req_o}, 32'h1);
        mstatus_mie_i = 1'b0; irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0; mstatus_mie_i = 1'b1;
        check_vec("ackwd_cool", {31'b0, irq_req_o}, 32'h0);
        step(1);
        check_vec("ackwd_idle", {31'b0, irq_req_o}, 32'h0);
        step(1);
        check_vec("ackwd_rereq", {31'b0, irq_req_o}, 32'h1);
        // Ack outside REQ is ignored
        mstatus_mie_i = 1'b0;
        step(1);
        irq_ack_i = 1'b1; mstatus_mie_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        check_vec("idle_ack_ignored", {31'b0, irq_req_o}, 32'h1);
        timer_irq_i = 1'b0; mie_i = 32'h0; mstatus_mie_i = 1'b0;
        step(2);

        // External synchroniser latency
        mie_i = 32'h800; mstatus_mie_i = 1'b1; ext_irq_i = 1'b1;
        step(2);
        check_vec("ext_c2_mip", mip_o, 32'h0);
        step(1);
        check_vec("ext_c3_mip", mip_o,              32'h800);
        check_vec("ext_c3_req", {31'b0, irq_req_o}, 32'h0);
        step(1);
        check_vec("ext_c4_req",   {31'b0, irq_req_o}, 32'h1);
        check_vec("ext_c4_cause", irq_cause_o,        32'h8000000B);

        // Reset mid-request
        rst_i = 1'b1;
        step(1);
        check_vec("midrst_req",   {31'b0, irq_req_o}, 32'h0);
        check_vec("midrst_cause", irq_cause_o,        32'h0);
        check_vec("midrst_mip",   mip_o,              32'h0);
        rst_i = 1'b0; ext_irq_i = 1'b0;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_irq_arbiter

// File: doc/irq_arbiter.md
# irq_arbiter

Machine-mode interrupt arbiter between the CLINT, the external interrupt line, and the core's trap logic. It synchronises and registers the three M-mode interrupt sources and exposes them as the live `mip` view for the CSR file. It masks them with `mie`/`mstatus.MIE`, selects one by fixed RISC-V priority, and presents a single interrupt request with a frozen `mcause` value to the pipeline under a request/acknowledge handshake. It also produces a WFI wakeup indication.

## Interface
- `XLEN`: global define, 32; width of cause/mask/mip words.
- `clk_i`  in  1  core clock; one clock for the whole block.
- `rst_i`  in  1  reset, synchronous, active-high.
- `timer_irq_i`  in  1  CLINT timer interrupt level (MTIP source).
- `software_irq_i`  in  1  CLINT software interrupt level (MSIP source).
- `ext_irq_i`  in  1  external interrupt level, asynchronous to `clk_i`.
- `mstatus_mie_i`  in  1  global M-mode interrupt enable from CSR file.
- `mie_i`  in  XLEN  `mie` CSR; only bits 3, 7, 11 are used.
- `mip_o`  out  XLEN  pending view: bit 3 = MSIP, bit 7 = MTIP, bit 11 = MEIP, all other bits 0.
- `irq_req_o`  out  1  interrupt request to the pipeline.
- `irq_cause_o`  out  XLEN  `mcause` value for the request; valid while `irq_req_o` = 1.
- `irq_ack_i`  in  1  pipeline has taken the trap; single-cycle pulse.
- `wakeup_o`  out  1  any pending & enabled in `mie`, independent of `mstatus_mie_i`; for WFI.

## Operation
- Source capture:
  - `timer_irq_i` and `software_irq_i` pass through one register stage into `mip_q`.
  - `ext_irq_i` passes through a 2-flop synchroniser, then `mip_q`.
  - `mip_o` = `mip_q`, which is a level view. Nothing is latched; writes to `mip` are not supported.
- Enabled set: `en = mip_q & mie_i` on bits 3/7/11. `take = (|en) & mstatus_mie_i`.
- Priority: MEI (cause 11) > MSI (3) > MTI (7).
- Cause encoding: `irq_cause_o = {1'b1, (XLEN-5)'b0, code[3:0]}`, i.e. 0x8000000B, 0x80000003, 0x80000007.
- FSM states: IDLE, REQ, COOL.
  - IDLE: if `take`, latch the winning cause and go to REQ. `irq_req_o` rises the next cycle.
  - REQ: `irq_req_o` = 1 and the cause is frozen. Later-arriving higher-priority sources do not change it.
    - `irq_ack_i` = 1 → COOL.
    - Else, `mstatus_mie_i` = 0 or `en` of the latched cause = 0 → withdraw to IDLE; `irq_req_o` drops the next cycle.
    - Ack and withdraw condition in the same cycle → ack wins, go to COOL.
  - COOL: one cycle with `irq_req_o` = 0, so the CSR-file clear of `mstatus.MIE` becomes visible. Unconditional return to IDLE.
- `irq_ack_i` outside REQ is ignored.
- `wakeup_o = |en`, combinational from `mip_q`/`mie_i`.

## Timing
- Reset: all sync flops, `mip_q`, latched cause, and `irq_req_o` are 0. `irq_cause_o` = 0, `mip_o` = 0, `wakeup_o` = 0, FSM = IDLE.
- Reset asserted in REQ or COOL → IDLE next cycle, request dropped, no ack expected.
- Latency, source rise to `irq_req_o`, with enables already set:
  - timer/software: 2 cycles (edge 1 → `mip_q`, edge 2 → REQ).
  - external: 4 cycles (2 sync + `mip_q` + REQ).
- Source fall to `mip_o` fall: 1 cycle (timer/software), 3 cycles (external).
- Earliest re-request after ack: ack at edge N → COOL at N, IDLE at N+1, REQ at N+2 if still `take`.
- `irq_cause_o` changes only on the IDLE→REQ transition; it holds its value in COOL/IDLE until the next latch.

## Structure
- Shared package `irq_pkg`:
  - Bit positions `MSI_BIT=3`, `MTI_BIT=7`, `MEI_BIT=11`.
  - Cause codes `CAUSE_MSI=3`, `CAUSE_MTI=7`, `CAUSE_MEI=11`.
  - Interrupt flag bit `XLEN-1`.
  - FSM state encoding `IRQ_IDLE/IRQ_REQ/IRQ_COOL`.
- One sub-module: `sync_2ff` (single-bit, reset-to-0 two-flop synchroniser), instantiated for `ext_irq_i`.

## Test plan
- Timer only: `mie_i`=0x80, `mstatus_mie_i`=1, raise `timer_irq_i` at cycle 0 → `mip_o`=0x80 at cycle 1; `irq_req_o`=1, `irq_cause_o`=0x80000007 at cycle 2; ack at cycle 4 → req 0 at cycle 5.
- Priority and freeze:
  - All three sources high simultaneously, `mie_i`=0x888 → cause 0x8000000B.
  - Software and timer only → cause 0x80000003.
  - Raise ext while in REQ with cause 3 → cause stays 0x80000003 until ack.
- Masking:
  - `mstatus_mie_i`=0, timer pending, `mie_i`=0x80 → `irq_req_o` stays 0, `wakeup_o`=1.
  - `mie_i`=0 → `wakeup_o`=0, `mip_o`=0x80.
- Withdraw vs ack:
  - In REQ drop `mstatus_mie_i` without ack → req 0 next cycle, FSM IDLE.
  - Repeat with ack in the same cycle → COOL, req 0, re-request 2 cycles later if still pending.
- External sync: pulse `ext_irq_i` high at cycle 0 with `mie_i`=0x800 → `mip_o` bit 11 at cycle 3, `irq_req_o` at cycle 4.
- Reset mid-request: assert `rst_i` while `irq_req_o`=1 → next cycle `irq_req_o`=0, `irq_cause_o`=0, `mip_o`=0.
